// File: rtl/moxie_wb_arbiter_pkg.sv
// Shared types and constants for the Moxie Wishbone arbiter.
package moxie_wb_arbiter_pkg;

  localparam int unsigned WB_ADR_W   = 32;
  localparam int unsigned WB_DAT_W   = 16;
  localparam int unsigned WB_SEL_W   = 2;
  localparam int unsigned STARVE_W   = 8;
  localparam int unsigned WDOG_CNT_W = 16;

  // Bus ownership; the slave port mux is selected directly by this value.
  typedef enum logic [1:0] {
    WB_ARB_IDLE  = 2'd0,
    WB_ARB_OWN_I = 2'd1,
    WB_ARB_OWN_D = 2'd2
  } wb_arb_state_e;

  // Everything the arbiter drives towards the slave.
  typedef struct packed {
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
    logic                cyc;
    logic                stb;
  } wb_slave_bus_t;

  // Winner of one arbitration round. Data wins ties unless fetch is starved.
  function automatic wb_arb_state_e arb_pick(input logic i_req,
                                             input logic d_req,
                                             input logic i_starved);
    wb_arb_state_e w_win;
    case ({i_req, d_req})
      2'b11:   w_win = i_starved ? WB_ARB_OWN_I : WB_ARB_OWN_D;
      2'b10:   w_win = WB_ARB_OWN_I;
      2'b01:   w_win = WB_ARB_OWN_D;
      default: w_win = WB_ARB_IDLE;
    endcase
    return w_win;
  endfunction

endpackage

// File: rtl/moxie_wb_watchdog.sv
// Bus-timeout watchdog: pulses expire_o on the TIMEOUT-th consecutive
// strobe cycle that has no ack. TIMEOUT = 0 disables it entirely.
module moxie_wb_watchdog
  import moxie_wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic stb_i,
  input  logic ack_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam bit                    LP_EN   = (TIMEOUT != 0);
  localparam logic [WDOG_CNT_W-1:0] LP_LAST = (TIMEOUT == 0) ? '0 : WDOG_CNT_W'(TIMEOUT - 1);

  logic [WDOG_CNT_W-1:0] r_cnt;
  logic                  w_expire;

  // r_cnt holds the number of earlier waiting cycles, so the current cycle
  // is the (r_cnt+1)-th; an ack in this cycle always beats expiry.
  assign w_expire = LP_EN & stb_i & ~ack_i & (r_cnt == LP_LAST);
  assign expire_o = w_expire;

  // Count consecutive un-acked strobe cycles; any break restarts the count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clear_i || !stb_i || ack_i || w_expire || !LP_EN) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + {{(WDOG_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/moxie_wb_arbiter.sv
// Registered two-master Wishbone arbiter (fetch vs data) for the Moxie core.
// Grant is held for a whole bus cycle; data normally wins ties, but after
// STARVE_LIMIT consecutive data wins against a pending fetch, fetch wins.
module moxie_wb_arbiter
  import moxie_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // fetch master
  input  logic [WB_ADR_W-1:0] wbi_adr_i,
  input  logic                wbi_cyc_i,
  input  logic                wbi_stb_i,
  output logic [WB_DAT_W-1:0] wbi_dat_o,
  output logic                wbi_ack_o,
  output logic                wbi_err_o,
  // data master
  input  logic [WB_ADR_W-1:0] wbd_adr_i,
  input  logic [WB_DAT_W-1:0] wbd_dat_i,
  input  logic [WB_SEL_W-1:0] wbd_sel_i,
  input  logic                wbd_we_i,
  input  logic                wbd_cyc_i,
  input  logic                wbd_stb_i,
  output logic [WB_DAT_W-1:0] wbd_dat_o,
  output logic                wbd_ack_o,
  output logic                wbd_err_o,
  // slave port
  output logic [WB_ADR_W-1:0] wb_adr_o,
  output logic [WB_DAT_W-1:0] wb_dat_o,
  output logic [WB_SEL_W-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic [WB_DAT_W-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  // core control
  output logic                stall_o,
  output logic                timeout_o
);

  localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  wb_arb_state_e       r_state;
  wb_arb_state_e       w_next_state;
  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_next_starve;
  logic                w_arb;
  logic                w_expire;
  logic                w_wdog_clear;
  wb_slave_bus_t       w_bus;

  // Route the owning master onto the slave port; idle drives all zero
  always_comb begin
    w_bus = '0;
    case (r_state)
      WB_ARB_OWN_I: begin
        w_bus.adr = wbi_adr_i;
        w_bus.sel = {WB_SEL_W{1'b1}};
        w_bus.cyc = wbi_cyc_i;
        w_bus.stb = wbi_stb_i;
      end
      WB_ARB_OWN_D: begin
        w_bus.adr = wbd_adr_i;
        w_bus.dat = wbd_dat_i;
        w_bus.sel = wbd_sel_i;
        w_bus.we  = wbd_we_i;
        w_bus.cyc = wbd_cyc_i;
        w_bus.stb = wbd_stb_i;
      end
      default: begin
        w_bus = '0;
      end
    endcase
  end

  // Next owner and starvation count; arbitrate whenever the bus is free
  always_comb begin
    w_next_state  = r_state;
    w_next_starve = r_starve_cnt;
    w_arb         = 1'b0;
    case (r_state)
      WB_ARB_IDLE:  w_arb = 1'b1;
      WB_ARB_OWN_I: w_arb = ~wbi_cyc_i;
      WB_ARB_OWN_D: w_arb = ~wbd_cyc_i;
      default:      w_arb = 1'b1;
    endcase
    if (w_expire) begin
      // A stuck transfer is abandoned; the master re-requests if it persists.
      w_next_state = WB_ARB_IDLE;
    end else if (w_arb) begin
      w_next_state = arb_pick(wbi_cyc_i, wbd_cyc_i, r_starve_cnt == LP_STARVE_MAX);
      if (w_next_state == WB_ARB_OWN_I) begin
        w_next_starve = '0;
      end else if ((w_next_state == WB_ARB_OWN_D) && wbi_cyc_i &&
                   (r_starve_cnt != LP_STARVE_MAX)) begin
        w_next_starve = r_starve_cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
      end else begin
        w_next_starve = r_starve_cnt;
      end
    end else begin
      w_next_state  = r_state;
      w_next_starve = r_starve_cnt;
    end
  end

  // Ownership state and starvation counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= WB_ARB_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_next_starve;
    end
  end

  // The watchdog restarts whenever ownership changes hands.
  assign w_wdog_clear = (w_next_state != r_state);

  moxie_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .stb_i    (w_bus.stb),
    .ack_i    (wb_ack_i),
    .clear_i  (w_wdog_clear),
    .expire_o (w_expire)
  );

  // Slave port; cyc/stb are withdrawn in the expiry cycle.
  assign wb_adr_o = w_bus.adr;
  assign wb_dat_o = w_bus.dat;
  assign wb_sel_o = w_bus.sel;
  assign wb_we_o  = w_bus.we;
  assign wb_cyc_o = w_bus.cyc & ~w_expire;
  assign wb_stb_o = w_bus.stb & ~w_expire;

  // Only the current owner ever sees an ack or an error.
  assign wbi_ack_o = wb_ack_i & wb_cyc_o & (r_state == WB_ARB_OWN_I);
  assign wbd_ack_o = wb_ack_i & wb_cyc_o & (r_state == WB_ARB_OWN_D);
  assign wbi_err_o = w_expire & (r_state == WB_ARB_OWN_I);
  assign wbd_err_o = w_expire & (r_state == WB_ARB_OWN_D);
  assign timeout_o = w_expire;

  assign wbi_dat_o = wb_dat_i;
  assign wbd_dat_o = wb_dat_i;

  // Pipeline freezes while a data access is outstanding.
  assign stall_o = wbd_cyc_i & ~wbd_ack_o;

endmodule

// File: tb/tb_moxie_wb_arbiter.sv
// Self-checking bench for moxie_wb_arbiter: a behavioural ownership model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_moxie_wb_arbiter;

  localparam int LP_STARVE = 4;
  localparam int LP_TMO    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wbi_adr = 32'h0;
  logic        wbi_cyc = 1'b0, wbi_stb = 1'b0;
  logic [31:0] wbd_adr = 32'h0;
  logic [15:0] wbd_dat = 16'h0;
  logic [1:0]  wbd_sel = 2'b00;
  logic        wbd_we = 1'b0, wbd_cyc = 1'b0, wbd_stb = 1'b0;
  logic [15:0] wb_dat_i = 16'h0;
  logic        wb_ack_i = 1'b0;

  logic [15:0] wbi_dat_o, wbd_dat_o, wb_dat_o;
  logic        wbi_ack_o, wbi_err_o, wbd_ack_o, wbd_err_o;
  logic [31:0] wb_adr_o;
  logic [1:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, stall_o, timeout_o;

  // second instance with the watchdog disabled
  logic [15:0] z_wbi_dat, z_wbd_dat, z_wb_dat;
  logic        z_wbi_ack, z_wbi_err, z_wbd_ack, z_wbd_err;
  logic [31:0] z_wb_adr;
  logic [1:0]  z_wb_sel;
  logic        z_wb_we, z_wb_cyc, z_wb_stb, z_stall, z_timeout;

  always #5 clk = ~clk;

  moxie_wb_arbiter #(.STARVE_LIMIT(LP_STARVE), .TIMEOUT(LP_TMO)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .wbi_adr_i(wbi_adr), .wbi_cyc_i(wbi_cyc), .wbi_stb_i(wbi_stb),
    .wbi_dat_o(wbi_dat_o), .wbi_ack_o(wbi_ack_o), .wbi_err_o(wbi_err_o),
    .wbd_adr_i(wbd_adr), .wbd_dat_i(wbd_dat), .wbd_sel_i(wbd_sel),
    .wbd_we_i(wbd_we), .wbd_cyc_i(wbd_cyc), .wbd_stb_i(wbd_stb),
    .wbd_dat_o(wbd_dat_o), .wbd_ack_o(wbd_ack_o), .wbd_err_o(wbd_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .stall_o(stall_o), .timeout_o(timeout_o)
  );

  moxie_wb_arbiter #(.STARVE_LIMIT(LP_STARVE), .TIMEOUT(0)) u_dut_nowdog (
    .clk_i(clk), .rst_i(rst),
    .wbi_adr_i(wbi_adr), .wbi_cyc_i(wbi_cyc), .wbi_stb_i(wbi_stb),
    .wbi_dat_o(z_wbi_dat), .wbi_ack_o(z_wbi_ack), .wbi_err_o(z_wbi_err),
    .wbd_adr_i(wbd_adr), .wbd_dat_i(wbd_dat), .wbd_sel_i(wbd_sel),
    .wbd_we_i(wbd_we), .wbd_cyc_i(wbd_cyc), .wbd_stb_i(wbd_stb),
    .wbd_dat_o(z_wbd_dat), .wbd_ack_o(z_wbd_ack), .wbd_err_o(z_wbd_err),
    .wb_adr_o(z_wb_adr), .wb_dat_o(z_wb_dat), .wb_sel_o(z_wb_sel),
    .wb_we_o(z_wb_we), .wb_cyc_o(z_wb_cyc), .wb_stb_o(z_wb_stb),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .stall_o(z_stall), .timeout_o(z_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: owner 0 = nobody, 1 = fetch, 2 = data. m_wait = strobe cycles
  // already spent waiting for an ack in the current transfer.
  int m_owner  = 0;
  int m_starve = 0;
  int m_wait   = 0;

  always @(negedge clk) begin : cmp
    logic [31:0] e_adr;
    logic [15:0] e_dat;
    logic [1:0]  e_sel;
    logic        e_we, e_cyc, e_stb, e_exp;
    logic        e_iack, e_dack, e_ierr, e_derr;
    int          nxt;
    bit          owner_busy;
    e_adr = 32'h0; e_dat = 16'h0; e_sel = 2'b00;
    e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_exp = 1'b0;
    if (rst) begin
      m_owner = 0; m_starve = 0; m_wait = 0;
    end else if (m_owner == 1) begin
      e_adr = wbi_adr; e_sel = 2'b11; e_cyc = wbi_cyc; e_stb = wbi_stb;
    end else if (m_owner == 2) begin
      e_adr = wbd_adr; e_dat = wbd_dat; e_sel = wbd_sel; e_we = wbd_we;
      e_cyc = wbd_cyc; e_stb = wbd_stb;
    end
    // this cycle would be the LP_TMO-th consecutive unanswered strobe
    e_exp  = e_stb && !wb_ack_i && (m_wait + 1 == LP_TMO);
    e_cyc  = e_cyc & ~e_exp;
    e_stb  = e_stb & ~e_exp;
    e_iack = (m_owner == 1) && wb_ack_i && e_cyc;
    e_dack = (m_owner == 2) && wb_ack_i && e_cyc;
    e_ierr = (m_owner == 1) && e_exp;
    e_derr = (m_owner == 2) && e_exp;

    chk("slave_bus", {11'h0, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o},
        {11'h0, e_adr, e_dat, e_sel, e_we, e_cyc, e_stb});
    chk("ack_err_tmo", {wbi_ack_o, wbi_err_o, wbd_ack_o, wbd_err_o, timeout_o},
        {e_iack, e_ierr, e_dack, e_derr, e_exp});
    chk("stall", stall_o, wbd_cyc && !e_dack);
    chk("rd_data", {wbi_dat_o, wbd_dat_o}, {wb_dat_i, wb_dat_i});
    chk("nowdog_no_err", {z_wbi_err, z_wbd_err, z_timeout}, 3'b000);

    if (!rst) begin
      owner_busy = (m_owner == 1 && wbi_cyc) || (m_owner == 2 && wbd_cyc);
      if (e_exp) nxt = 0;
      else if (owner_busy) nxt = m_owner;
      else if (wbi_cyc && wbd_cyc) nxt = (m_starve == LP_STARVE) ? 1 : 2;
      else if (wbi_cyc) nxt = 1;
      else if (wbd_cyc) nxt = 2;
      else nxt = 0;
      if (!e_exp && !owner_busy) begin
        if (nxt == 1) m_starve = 0;
        else if (nxt == 2 && wbi_cyc && m_starve < LP_STARVE) m_starve = m_starve + 1;
      end
      if (nxt != m_owner || !(m_owner != 0 && (m_owner == 1 ? wbi_stb : wbd_stb)) ||
          wb_ack_i || e_exp)
        m_wait = 0;
      else
        m_wait = m_wait + 1;
      m_owner = nxt;
    end
  end

  int ack_i_cnt = 0;
  always @(negedge clk) if (wbi_ack_o) ack_i_cnt++;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  grants_d, first_i, hi_cnt, tmo_cnt;
    bit  prev_cyc, seen_err, got;

    // reset and idle
    repeat (2) @(negedge clk);
    chk("rst_outputs", {wb_cyc_o, wb_stb_o, wbi_ack_o, wbd_ack_o, timeout_o}, 5'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    step(); rst = 1'b0;
    repeat (2) step();

    // T1: fetch read, ack after two wait cycles
    wbi_adr = 32'h1000; wbi_cyc = 1'b1; wbi_stb = 1'b1;
    @(negedge clk); chk("t1_idle_cyc", wb_cyc_o, 1'b0);
    step();
    @(negedge clk);
    chk("t1_adr", wb_adr_o, 32'h1000); chk("t1_sel", wb_sel_o, 2'b11); chk("t1_cyc", wb_cyc_o, 1'b1);
    step();
    step(); wb_ack_i = 1'b1; wb_dat_i = 16'h1234;
    @(negedge clk);
    chk("t1_ack", wbi_ack_o, 1'b1); chk("t1_dat", wbi_dat_o, 16'h1234); chk("t1_dack", wbd_ack_o, 1'b0);
    step(); wb_ack_i = 1'b0; wbi_cyc = 1'b0; wbi_stb = 1'b0;
    repeat (2) step();
    chk("t1_ack_pulses", ack_i_cnt, 1);

    // T2: simultaneous request, data write first, then fetch
    wbi_adr = 32'h1004; wbi_cyc = 1'b1; wbi_stb = 1'b1;
    wbd_adr = 32'h2000; wbd_dat = 16'hBEEF; wbd_sel = 2'b01; wbd_we = 1'b1;
    wbd_cyc = 1'b1; wbd_stb = 1'b1;
    @(negedge clk); chk("t2_stall_req", stall_o, 1'b1);
    step();
    @(negedge clk);
    chk("t2_adr", wb_adr_o, 32'h2000); chk("t2_dat", wb_dat_o, 16'hBEEF);
    chk("t2_sel", wb_sel_o, 2'b01); chk("t2_we", wb_we_o, 1'b1); chk("t2_stall", stall_o, 1'b1);
    step(); wb_ack_i = 1'b1; wb_dat_i = 16'h0000;
    @(negedge clk); chk("t2_dack", wbd_ack_o, 1'b1); chk("t2_stall_ack", stall_o, 1'b0);
    step(); wb_ack_i = 1'b0; wbd_cyc = 1'b0; wbd_stb = 1'b0; wbd_we = 1'b0;
    @(negedge clk); chk("t2_drop_cycle", wb_cyc_o, 1'b0);
    step();
    @(negedge clk); chk("t2_i_grant", wb_cyc_o, 1'b1); chk("t2_i_adr", wb_adr_o, 32'h1004);
    step(); wb_ack_i = 1'b1; wb_dat_i = 16'h4321;
    @(negedge clk); chk("t2_iack", wbi_ack_o, 1'b1);
    step(); wb_ack_i = 1'b0; wbi_cyc = 1'b0; wbi_stb = 1'b0;
    repeat (2) step();

    // T3: data stuck and never dropping cyc, fetch pending: starvation
    wbi_adr = 32'h3000; wbi_cyc = 1'b1; wbi_stb = 1'b1;
    wbd_adr = 32'h4000; wbd_sel = 2'b11; wbd_cyc = 1'b1; wbd_stb = 1'b1;
    grants_d = 0; first_i = -1; hi_cnt = 0; tmo_cnt = 0; prev_cyc = 1'b0; seen_err = 1'b0;
    for (int c = 0; c < 80 && first_i < 0; c++) begin
      @(negedge clk);
      if (timeout_o) tmo_cnt++;
      if (wbd_err_o) seen_err = 1'b1;
      if (!seen_err && wb_cyc_o) hi_cnt++;
      if (wb_cyc_o && !prev_cyc) begin
        if (wb_adr_o == 32'h4000) grants_d++;
        else if (wb_adr_o == 32'h3000) first_i = grants_d;
      end
      prev_cyc = wb_cyc_o;
    end
    chk("t3_d_grants_before_i", first_i, 4);
    chk("t3_cyc_cycles_before_err", hi_cnt, 7);
    chk("t3_timeout_pulses", tmo_cnt, 4);
    chk("t3_model_starve_cleared", m_starve, 0);
    chk("t0_still_owned", z_wb_cyc, 1'b1);
    step(); wb_ack_i = 1'b1; wb_dat_i = 16'h5555;
    @(negedge clk); chk("t3_iack", wbi_ack_o, 1'b1); chk("t3_no_dack", wbd_ack_o, 1'b0);
    step(); wb_ack_i = 1'b0; wbi_cyc = 1'b0; wbi_stb = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (wbd_err_o) got = 1'b1;
    end
    chk("t3_second_err", got, 1'b1);
    chk("t3_err_cyc_low", wb_cyc_o, 1'b0);
    chk("t3_err_tmo", timeout_o, 1'b1);
    step(); wbd_cyc = 1'b0; wbd_stb = 1'b0;
    repeat (2) step();

    // T4: ack arrives in the would-be expiry cycle
    wbd_adr = 32'h6000; wbd_cyc = 1'b1; wbd_stb = 1'b1; wbd_we = 1'b0;
    step();
    repeat (6) step();
    @(negedge clk); chk("t4_no_early_err", wbd_err_o, 1'b0);
    step(); wb_ack_i = 1'b1; wb_dat_i = 16'hA5A5;
    @(negedge clk);
    chk("t4_ack", wbd_ack_o, 1'b1); chk("t4_no_err", {wbd_err_o, timeout_o}, 2'b00);
    chk("t4_cyc", wb_cyc_o, 1'b1); chk("t4_dat", wbd_dat_o, 16'hA5A5);
    step(); wb_ack_i = 1'b0; wbd_cyc = 1'b0; wbd_stb = 1'b0;
    repeat (2) step();

    // T5: reset in the middle of a data transfer
    wbi_adr = 32'h8000; wbi_cyc = 1'b1; wbi_stb = 1'b1;
    wbd_adr = 32'h7000; wbd_dat = 16'h1111; wbd_we = 1'b1; wbd_cyc = 1'b1; wbd_stb = 1'b1;
    step();
    @(negedge clk); chk("t5_owned", wb_cyc_o, 1'b1);
    step(); rst = 1'b1; #1; wb_ack_i = 1'b1; #1;
    chk("t5_rst_cyc", wb_cyc_o, 1'b0);
    chk("t5_rst_acks", {wbi_ack_o, wbd_ack_o}, 2'b00);
    chk("t5_rst_stall", stall_o, 1'b1);
    @(negedge clk);
    step(); rst = 1'b0; wb_ack_i = 1'b0;
    step();
    @(negedge clk); chk("t5_regrant_d", wb_adr_o, 32'h7000);
    step(); wb_ack_i = 1'b1;
    step(); wb_ack_i = 1'b0; wbd_cyc = 1'b0; wbd_stb = 1'b0; wbd_we = 1'b0;
    step();
    @(negedge clk); chk("t5_then_i", wb_adr_o, 32'h8000);
    step(); wb_ack_i = 1'b1;
    step(); wb_ack_i = 1'b0; wbi_cyc = 1'b0; wbi_stb = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
